// File: rtl/elevator_ctrl_n.sv
// Single-car elevator controller, NUM_FLOORS floors.
// Collective-scan service with prescaled travel and door timing.
module elevator_ctrl_n #(
    parameter int NUM_FLOORS   = 4,
    parameter int FLOOR_W      = 2,
    parameter int TICK_DIV     = 50000000,
    parameter int TRAVEL_TICKS = 3,
    parameter int DOOR_TICKS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] car_btn,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_dn,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrive,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0]         PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0]         TRV_LAST  = TW'(TRAVEL_TICKS - 1);
    localparam logic [TW-1:0]         DOOR_LAST = TW'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0]    TOP       = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] UP_OK     = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_OK     = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
    localparam logic [NUM_FLOORS-1:0] ONE       = NUM_FLOORS'(1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_pre;
    logic [TW-1:0]         r_tmr;
    logic [FLOOR_W-1:0]    r_floor;
    logic                  r_dir;
    logic                  r_moving;
    logic                  r_door;
    logic                  r_arrive;
    logic [NUM_FLOORS-1:0] r_car;
    logic [NUM_FLOORS-1:0] r_up;
    logic [NUM_FLOORS-1:0] r_dn;

    logic                  w_tick;
    logic [NUM_FLOORS-1:0] w_pend;
    logic [NUM_FLOORS-1:0] w_here_oh;
    logic                  w_here;
    logic                  w_ahd_up;
    logic                  w_ahd_dn;
    logic                  w_ahd_fwd;
    logic                  w_ahd_rev;
    logic                  w_at_end;
    logic                  w_step;
    logic [FLOOR_W-1:0]    w_nf;
    logic [NUM_FLOORS-1:0] w_nf_oh;
    logic                  w_nf_ahd;
    logic [NUM_FLOORS-1:0] w_fwd_hall;
    logic                  w_stop;
    logic [NUM_FLOORS-1:0] w_fwd_btn;
    logic                  w_restart;
    logic                  w_door_done;

    logic [FLOOR_W-1:0]    w_floor_nxt;
    logic                  w_dir_nxt;
    logic                  w_arrive_nxt;
    logic [TW-1:0]         w_tmr_nxt;
    logic [NUM_FLOORS-1:0] w_clr_car;
    logic [NUM_FLOORS-1:0] w_clr_up;
    logic [NUM_FLOORS-1:0] w_clr_dn;
    logic [NUM_FLOORS-1:0] w_blk_car;
    logic [NUM_FLOORS-1:0] w_blk_up;
    logic [NUM_FLOORS-1:0] w_blk_dn;

    function automatic logic f_above(
        input logic [NUM_FLOORS-1:0] v,
        input logic [FLOOR_W-1:0]    f
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f)) r = r | v[i];
        end
        return r;
    endfunction

    function automatic logic f_below(
        input logic [NUM_FLOORS-1:0] v,
        input logic [FLOOR_W-1:0]    f
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f)) r = r | v[i];
        end
        return r;
    endfunction

    assign w_tick     = (r_pre == PRE_LAST);
    assign w_pend     = r_car | r_up | r_dn;
    assign w_here_oh  = ONE << r_floor;
    assign w_here     = |(w_pend & w_here_oh);
    assign w_ahd_up   = f_above(w_pend, r_floor);
    assign w_ahd_dn   = f_below(w_pend, r_floor);
    assign w_ahd_fwd  = r_dir ? w_ahd_up : w_ahd_dn;
    assign w_ahd_rev  = r_dir ? w_ahd_dn : w_ahd_up;
    assign w_at_end   = r_dir ? (r_floor == TOP) : (r_floor == '0);
    assign w_step     = (r_state == S_MOVE) && w_tick && (r_tmr == TRV_LAST);

    // Next floor is clamped so the car can never run past either end.
    assign w_nf       = w_at_end ? r_floor :
                        (r_dir ? r_floor + FLOOR_W'(1) : r_floor - FLOOR_W'(1));
    assign w_nf_oh    = ONE << w_nf;
    assign w_nf_ahd   = r_dir ? f_above(w_pend, w_nf) : f_below(w_pend, w_nf);
    assign w_fwd_hall = r_dir ? r_up : r_dn;
    assign w_stop     = (|(w_nf_oh & (r_car | w_fwd_hall))) | ~w_nf_ahd;

    // Presses at the open-door floor hold the door instead of latching.
    assign w_fwd_btn  = r_dir ? (hall_up & UP_OK) : (hall_dn & DN_OK);
    assign w_restart  = (r_state == S_DOOR) &&
                        (|(w_here_oh & (car_btn | w_fwd_btn)));
    assign w_door_done = (r_state == S_DOOR) && w_tick &&
                         (r_tmr == DOOR_LAST) && !w_restart;

    // Free-running tick prescaler.
    always_ff @(posedge clk) begin
        if (reset) r_pre <= '0;
        else       r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_here)                      w_state_nxt = S_DOOR;
                else if (w_ahd_fwd || w_ahd_rev) w_state_nxt = S_MOVE;
            end
            S_MOVE: if (w_step && w_stop) w_state_nxt = S_DOOR;
            S_DOOR: if (w_door_done)      w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-state datapath: timers, floor step, service clears.
    always_comb begin
        w_floor_nxt  = r_floor;
        w_dir_nxt    = r_dir;
        w_arrive_nxt = 1'b0;
        w_tmr_nxt    = r_tmr;
        w_clr_car    = '0;
        w_clr_up     = '0;
        w_clr_dn     = '0;
        w_blk_car    = '0;
        w_blk_up     = '0;
        w_blk_dn     = '0;
        unique case (r_state)
            S_IDLE: begin
                w_tmr_nxt = '0;
                if (w_here) begin
                    w_clr_car    = w_here_oh;
                    w_clr_up     = w_here_oh;
                    w_clr_dn     = w_here_oh;
                    w_arrive_nxt = 1'b1;
                end else if (!w_ahd_fwd && w_ahd_rev) begin
                    w_dir_nxt = ~r_dir;
                end
            end
            S_MOVE: begin
                if (w_tick) begin
                    w_tmr_nxt = (r_tmr == TRV_LAST) ? '0 : r_tmr + TW'(1);
                end
                if (w_step) begin
                    w_floor_nxt = w_nf;
                    if (w_stop) begin
                        w_arrive_nxt = 1'b1;
                        w_clr_car    = w_nf_oh;
                        if (r_dir || !w_nf_ahd) w_clr_up = w_nf_oh;
                        if (!r_dir || !w_nf_ahd) w_clr_dn = w_nf_oh;
                    end
                end
            end
            S_DOOR: begin
                w_blk_car = w_here_oh;
                if (r_dir) w_blk_up = w_here_oh;
                else       w_blk_dn = w_here_oh;
                if (w_restart) begin
                    w_tmr_nxt = '0;
                end else if (w_tick) begin
                    w_tmr_nxt = (r_tmr == DOOR_LAST) ? '0 : r_tmr + TW'(1);
                end
            end
            default: w_tmr_nxt = '0;
        endcase
    end

    // Datapath and registered output update; a press beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmr    <= '0;
            r_floor  <= '0;
            r_dir    <= 1'b1;
            r_moving <= 1'b0;
            r_door   <= 1'b0;
            r_arrive <= 1'b0;
            r_car    <= '0;
            r_up     <= '0;
            r_dn     <= '0;
        end else begin
            r_tmr    <= w_tmr_nxt;
            r_floor  <= w_floor_nxt;
            r_dir    <= w_dir_nxt;
            r_moving <= (w_state_nxt == S_MOVE);
            r_door   <= (w_state_nxt == S_DOOR);
            r_arrive <= w_arrive_nxt;
            r_car    <= (r_car & ~w_clr_car) | (car_btn & ~w_blk_car);
            r_up     <= (r_up & ~w_clr_up) | (hall_up & UP_OK & ~w_blk_up);
            r_dn     <= (r_dn & ~w_clr_dn) | (hall_dn & DN_OK & ~w_blk_dn);
        end
    end

    assign current_floor = r_floor;
    assign dir_up        = r_dir;
    assign moving        = r_moving;
    assign door_open     = r_door;
    assign arrive        = r_arrive;
    assign pending       = w_pend;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Bench for elevator_ctrl_n: 4-floor and 8-floor instances.
// Arrivals are scoreboarded; timing and boundaries checked inline.
module tb_elevator_ctrl_n;

    typedef struct {
        int fl;
        int pe;
        int du;
    } exp_t;

    logic       clk;
    logic       rst;

    logic [3:0] c4, u4, d4, pe4;
    logic [1:0] f4;
    logic       dir4, mv4, do4, ar4;

    logic [7:0] c8, u8, d8, pe8;
    logic [2:0] f8;
    logic       dir8, mv8, do8, ar8;

    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;

    int n_chk = 0;
    int n_err = 0;

    elevator_ctrl_n #(
        .NUM_FLOORS(4), .FLOOR_W(2), .TICK_DIV(1),
        .TRAVEL_TICKS(4), .DOOR_TICKS(3)
    ) u_dut4 (
        .clk(clk), .reset(rst),
        .car_btn(c4), .hall_up(u4), .hall_dn(d4),
        .current_floor(f4), .dir_up(dir4), .moving(mv4),
        .door_open(do4), .arrive(ar4), .pending(pe4)
    );

    elevator_ctrl_n #(
        .NUM_FLOORS(8), .FLOOR_W(3), .TICK_DIV(2),
        .TRAVEL_TICKS(4), .DOOR_TICKS(3)
    ) u_dut8 (
        .clk(clk), .reset(rst),
        .car_btn(c8), .hall_up(u8), .hall_dn(d8),
        .current_floor(f8), .dir_up(dir8), .moving(mv8),
        .door_open(do8), .arrive(ar8), .pending(pe8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ar4 === 1'b1) begin
            if (q4.size() == 0) begin
                check("arr4_unexpected", 1, 0);
            end else begin
                e4 = q4.pop_front();
                check("arr4_floor", 32'(f4), e4.fl);
                check("arr4_pend", 32'(pe4), e4.pe);
                check("arr4_dir", 32'(dir4), e4.du);
            end
        end
        if (ar8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("arr8_unexpected", 1, 0);
            end else begin
                e8 = q8.pop_front();
                check("arr8_floor", 32'(f8), e8.fl);
                check("arr8_pend", 32'(pe8), e8.pe);
                check("arr8_dir", 32'(dir8), e8.du);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle4(input string tag, input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (!mv4 && !do4 && pe4 == 0 && q4.size() == 0) ok = 1'b1;
        end
        check(tag, 32'(ok), 1);
    endtask

    initial begin
        int dc, bad, pbad, steps, badstep, badint, lc, pf;
        bit ok;
        rst = 1'b1;
        c4 = '0; u4 = '0; d4 = '0;
        c8 = '0; u8 = '0; d8 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_floor4", 32'(f4), 0);
        check("rst_dir4", 32'(dir4), 1);
        check("rst_moving4", 32'(mv4), 0);
        check("rst_door4", 32'(do4), 0);
        check("rst_arrive4", 32'(ar4), 0);
        check("rst_pend4", 32'(pe4), 0);
        check("rst_floor8", 32'(f8), 0);
        check("rst_pend8", 32'(pe8), 0);

        // single car call to floor 2
        q4.push_back('{2, 0, 1});
        c4 = 4'b0100;
        @(negedge clk);
        c4 = '0;
        check("t1_latch", 32'(pe4), 4);
        check("t1_mv_early", 32'(mv4), 0);
        @(negedge clk);
        check("t1_mv_rise", 32'(mv4), 1);
        repeat (3) @(negedge clk);
        check("t1_floor0", 32'(f4), 0);
        @(negedge clk);
        check("t1_floor1", 32'(f4), 1);
        repeat (3) @(negedge clk);
        check("t1_floor1b", 32'(f4), 1);
        @(negedge clk);
        check("t1_floor2", 32'(f4), 2);
        check("t1_door_on", 32'(do4), 1);
        check("t1_mv_off", 32'(mv4), 0);
        dc = 0;
        for (int i = 0; i < 10; i++) begin
            if (do4) dc++;
            @(negedge clk);
        end
        check("t1_door_len", 32'(dc), 3);
        check("t1_pend_end", 32'(pe4), 0);
        check("t1_idle", 32'(mv4), 0);

        // collective scan with hall calls, then reversal
        do_reset();
        q4.push_back('{2, 10, 1});
        q4.push_back('{3, 2, 1});
        q4.push_back('{1, 0, 0});
        c4 = 4'b1000;
        @(negedge clk);
        c4 = '0;
        d4 = 4'b0010;
        u4 = 4'b0100;
        @(negedge clk);
        d4 = '0;
        u4 = '0;
        wait_idle4("t2_done", 300);
        check("t2_floor", 32'(f4), 1);
        check("t2_dir", 32'(dir4), 0);
        check("t2_pend", 32'(pe4), 0);

        // door at current floor, extended by a repeat press
        repeat (2) @(negedge clk);
        q4.push_back('{1, 0, 0});
        c4 = 4'b0010;
        @(negedge clk);
        c4 = '0;
        @(negedge clk);
        check("t3_door_open", 32'(do4), 1);
        @(negedge clk);
        c4 = 4'b0010;
        @(negedge clk);
        c4 = '0;
        check("t3_no_latch", 32'(pe4), 0);
        dc = 2;
        for (int i = 0; i < 12; i++) begin
            if (do4) dc++;
            @(negedge clk);
        end
        check("t3_door_len", 32'(dc), 5);
        check("t3_pend_end", 32'(pe4), 0);
        check("t3_mv", 32'(mv4), 0);

        // masked hall bits never latch
        d4 = 4'b0001;
        u4 = 4'b1000;
        bad = 0;
        pbad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mv4 || do4) bad++;
            if (pe4 != 0) pbad++;
        end
        d4 = '0;
        u4 = '0;
        check("t4_no_motion", 32'(bad), 0);
        check("t4_no_pend", 32'(pbad), 0);

        // 8-floor run to the top, prescaled ticks
        q8.push_back('{7, 0, 1});
        c8 = 8'h80;
        @(negedge clk);
        c8 = '0;
        steps = 0;
        badstep = 0;
        badint = 0;
        lc = 0;
        pf = int'(f8);
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge clk);
            if (int'(f8) != pf) begin
                if (int'(f8) != pf + 1) badstep++;
                if (steps > 0 && cyc - lc != 8) badint++;
                steps++;
                lc = cyc;
                pf = int'(f8);
            end
        end
        check("t5_steps", 32'(steps), 7);
        check("t5_badstep", 32'(badstep), 0);
        check("t5_interval", 32'(badint), 0);
        check("t5_floor", 32'(f8), 7);
        check("t5_mv", 32'(mv8), 0);
        check("t5_pend", 32'(pe8), 0);

        // reset mid-travel
        do_reset();
        c4 = 4'b1000;
        @(negedge clk);
        c4 = '0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (f4 == 2'd1) ok = 1'b1;
        end
        check("t6_reach1", 32'(ok), 1);
        @(negedge clk);
        check("t6_midmove", 32'(mv4), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_floor", 32'(f4), 0);
        check("t6_moving", 32'(mv4), 0);
        check("t6_pend", 32'(pe4), 0);
        check("t6_dir", 32'(dir4), 1);
        check("t6_door", 32'(do4), 0);
        repeat (10) @(negedge clk);
        check("t6_stays", 32'(mv4), 0);

        check("q4_drained", 32'(q4.size()), 0);
        check("q8_drained", 32'(q8.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
